// File: rtl/ram_separate_io_core_if.sv
// Bus bundle for ram_separate_io_core: write enable, shared address,
// write data in and read data out.
interface ram_separate_io_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/ram_separate_io_core.sv
// Flop-based scratch RAM: synchronous write, combinational read, cleared by rst_n.
// Optional macro RAM_SEP_IO_WR_BYPASS_EN forwards data_in to data_out while we=1.
module ram_separate_io_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_separate_io_core_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_s;

    // Storage: whole array clears asynchronously; reset has priority over writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bus.we) begin
            mem_r[bus.addr] <= bus.data_in;
        end else begin
            mem_r[bus.addr] <= mem_r[bus.addr];
        end
    end

    // Read path: array lookup, optionally overridden by the word being written
    always_comb begin
        rd_s = mem_r[bus.addr];
`ifdef RAM_SEP_IO_WR_BYPASS_EN
        if (bus.we) begin
            rd_s = bus.data_in;
        end else begin
            rd_s = mem_r[bus.addr];
        end
`endif
    end

    // Output gating: bypassed data must not leak out while reset is held
    always_comb begin
        if (!rst_n) begin
            bus.data_out = {DATA_WIDTH{1'b0}};
        end else begin
            bus.data_out = rd_s;
        end
    end
endmodule

// File: tb/tb_ram_separate_io_core.sv
// Self-checking bench for ram_separate_io_core: directed scenarios with literal
// expectations plus a per-cycle comparison against an array model.
module tb_ram_separate_io_core;
`ifdef RAM_SEP_IO_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic check_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] model_mem [256];

    ram_separate_io_core_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    ram_separate_io_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: what the RAM must hold after each edge
    always @(posedge clk) begin
        if (rst_n === 1'b1 && bus.we === 1'b1) model_mem[bus.addr] <= bus.data_in;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 256; i++) model_mem[i] <= 8'h00;
    end

    function automatic logic [7:0] expected_out();
        if (rst_n !== 1'b1) return 8'h00;
        if (BYP && bus.we === 1'b1) return bus.data_in;
        return model_mem[bus.addr];
    endfunction

    // Mid-cycle comparison against the model on every cycle
    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (bus.data_out !== expected_out()) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t addr=%h we=%b got=%h exp=%h",
                         $time, bus.addr, bus.we, bus.data_out, expected_out());
            end
        end
    end

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (bus.data_out !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, bus.data_out, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sync();
        bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        sync();
        bus.we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        sync();
        bus.addr = a;
        #1;
        check(name, exp);
        n_cmp++;
        if (model_mem[a] !== exp) begin
            n_bad++;
            $display("FAIL model_pin_%s got=%h exp=%h", name, model_mem[a], exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        rst_n = 1'b0; bus.we = 1'b0; bus.addr = 8'h10; bus.data_in = 8'h00;
        #2;
        check("reset_state", 8'h00);
        #5 rst_n = 1'b1;
        check_en = 1'b1;

        // Reset clears stored data and blocks writes while held
        wr(8'h10, 8'hAA);
        #1 check("pre_reset_rd", 8'hAA);
        #1 rst_n = 1'b0;
        #1 check("rst_async", 8'h00);
        bus.we = 1'b1; bus.data_in = 8'h55;
        sync();
        check("rst_hold", 8'h00);
        bus.we = 1'b0;
        #2 rst_n = 1'b1;
        rd("rst_clear", 8'h10, 8'h00);

        // Basic write then read
        wr(8'h05, 8'h3C);
        rd("basic", 8'h05, 8'h3C);

        // Read during write
        wr(8'h22, 8'h11);
        sync();
        bus.we = 1'b1; bus.addr = 8'h22; bus.data_in = 8'h99;
        #1 check("rdw_before", BYP ? 8'h99 : 8'h11);
        sync();
        check("rdw_after", 8'h99);
        bus.we = 1'b0;
        #1 check("rdw_after_we0", 8'h99);

        // Address boundaries
        wr(8'h00, 8'h01);
        wr(8'hFF, 8'hFE);
        rd("bound_lo", 8'h00, 8'h01);
        rd("bound_hi", 8'hFF, 8'hFE);
        rd("bound_alias", 8'h80, 8'h00);

        // Back-to-back writes, last write wins
        sync();
        bus.we = 1'b1; bus.addr = 8'h03; bus.data_in = 8'h0A;
        sync();
        bus.data_in = 8'h0B;
        sync();
        bus.addr = 8'h04; bus.data_in = 8'h0C;
        sync();
        bus.we = 1'b0;
        rd("b2b_a3", 8'h03, 8'h0B);
        rd("b2b_a4", 8'h04, 8'h0C);

        // Random traffic checked by the per-cycle comparison
        for (int i = 0; i < 1000; i++) begin
            sync();
            bus.we      = 1'($urandom_range(0, 1));
            bus.addr    = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            bus.data_in = 8'($urandom_range(0, 255));
        end
        sync();
        bus.we = 1'b0;
        sync();
        sync();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
